serial_adder_n: RTL and testbench

//  Parametrised multi-cycle adder, WIDTH bits wide, processing CHUNK bits per clock.

---
 rtl/serial_adder_n.sv | 159 +++++++++++++++
 tb/tb_serial_adder_n.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// serial_adder_n
//   Multi-cycle unsigned adder. A WIDTH-bit sum is built CHUNK bits per clock,
//   reusing one CHUNK-wide carry chain NCH = WIDTH/CHUNK times.
//   Handshake: START is accepted whenever BUSY=0 (IDLE or FIN). BUSY is high
//   for NCH cycles. DONE then pulses for one cycle, and S/COUT update on the
//   same edge.
//
// Parameters
//   WIDTH  operand and sum width (>= 1)
//   CHUNK  bits added per clock; WIDTH % CHUNK must be 0
//
// Ports
//   CLK    clock, rising edge
//   RST    synchronous reset, active-high; has priority over START
//   START  operation request, sampled only while BUSY=0
//   A, B   WIDTH-bit operands, captured on the accepting edge
//   CIN    carry-in, captured on the accepting edge
//   SUB    (only with ADDER_SUB_EN) 1 = compute A - B; COUT=1 means no borrow
//   S      registered sum, held until the next completion
//   COUT   registered carry-out, updated together with S
//   BUSY   high while an operation is in progress
//   DONE   one-cycle completion pulse
//
// Build option
//   ADDER_SUB_EN  adds the SUB port and the operand-inversion logic
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
`ifdef ADDER_SUB_EN
    input  logic             SUB,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("serial_adder_n: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic [WIDTH-1:0] res_next;
    logic             last_chunk;
    logic             accept;
    logic [WIDTH-1:0] b_cap;
    logic             c_cap;

    // Operand conditioning at capture time
`ifdef ADDER_SUB_EN
    // Subtraction is A + ~B + 1, so the incoming CIN is ignored.
    always_comb begin
        b_cap = SUB ? ~B : B;
        c_cap = SUB ? 1'b1 : CIN;
    end
`else
    always_comb begin
        b_cap = B;
        c_cap = CIN;
    end
`endif

    assign accept     = START && (state != RUN);
    assign last_chunk = (cnt == CW'(NCH - 1));

    // Chunk adder and result assembly.
    // Each new chunk enters at the top of the result register, so after NCH
    // shifts the first (least significant) chunk has reached bit 0.
    always_comb begin
        {c_chunk, s_chunk} = {1'b0, a_reg[CHUNK-1:0]}
                           + {1'b0, b_reg[CHUNK-1:0]}
                           + {{CHUNK{1'b0}}, carry};
        res_next = (res_reg >> CHUNK) | (WIDTH'(s_chunk) << (WIDTH - CHUNK));
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = START ? RUN : IDLE;
            RUN:     state_next = last_chunk ? FIN : RUN;
            FIN:     state_next = START ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = (state == RUN);
        DONE = (state == FIN);
    end

    // Datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            S       <= '0;
            COUT    <= 1'b0;
        end else if (accept) begin
            a_reg   <= A;
            b_reg   <= b_cap;
            carry   <= c_cap;
            cnt     <= '0;
            res_reg <= '0;
        end else if (state == RUN) begin
            a_reg   <= a_reg >> CHUNK;
            b_reg   <= b_reg >> CHUNK;
            res_reg <= res_next;
            carry   <= c_chunk;
            cnt     <= cnt + CW'(1);
            // The final sum is taken from the adder output directly, so S/COUT
            // change on the same edge that enters FIN.
            if (last_chunk) begin
                S    <= res_next;
                COUT <= c_chunk;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n
//   Directed bench for serial_adder_n: one instance with WIDTH=8/CHUNK=2,
//   plus one with CHUNK=WIDTH=8 for the single-chunk case.
module tb_serial_adder_n;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       SUB;
    logic [7:0] A;
    logic [7:0] B;
    logic       CIN;
    logic [7:0] S;
    logic       COUT;
    logic       BUSY;
    logic       DONE;

    logic       START8;
    logic [7:0] S8;
    logic       COUT8;
    logic       BUSY8;
    logic       DONE8;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    serial_adder_n #(.WIDTH(8), .CHUNK(2)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
`ifdef ADDER_SUB_EN
        .SUB   (SUB),
`endif
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .S     (S),
        .COUT  (COUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    serial_adder_n #(.WIDTH(8), .CHUNK(8)) dut8 (
        .CLK   (CLK),
        .RST   (RST),
        .START (START8),
`ifdef ADDER_SUB_EN
        .SUB   (SUB),
`endif
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .S     (S8),
        .COUT  (COUT8),
        .BUSY  (BUSY8),
        .DONE  (DONE8)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives a single operation on dut and waits for DONE (bounded).
    // lat = number of edges from the accepting edge up to the DONE cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output int lat);
        A     = a;
        B     = b;
        CIN   = cin;
        START = 1'b1;
        tick();
        START = 1'b0;
        lat   = 1;
        while (!DONE && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; START8 = 1'b0; SUB = 1'b0;
        A = 8'h00; B = 8'h00; CIN = 1'b0;
        tick(); tick();
        RST = 1'b0;
        tests++;
        if (S !== 8'h00 || COUT !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: S=%h COUT=%b BUSY=%b DONE=%b, want 00 0 0 0",
                     S, COUT, BUSY, DONE);
        end
    endtask

    task automatic test_basic();
        A = 8'h3C; B = 8'h0F; CIN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            // Operands are captured, so scribbling on them must not matter.
            A = 8'hA5; B = 8'h5A; CIN = 1'b1;
            tests++;
            if (BUSY !== 1'b1 || DONE !== 1'b0) begin
                fails++;
                $display("FAIL basic_busy cycle %0d: BUSY=%b DONE=%b, want 1 0", i, BUSY, DONE);
            end
            tick();
        end
        tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || S !== 8'h4B || COUT !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: DONE=%b BUSY=%b S=%h COUT=%b, want 1 0 4b 0",
                     DONE, BUSY, S, COUT);
        end
        tick();
        tests++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || S !== 8'h4B) begin
            fails++;
            $display("FAIL basic_after: DONE=%b BUSY=%b S=%h, want 0 0 4b", DONE, BUSY, S);
        end
    endtask

    task automatic test_carry();
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, lat);
        tests++;
        if (lat !== 5 || S !== 8'h00 || COUT !== 1'b1) begin
            fails++;
            $display("FAIL carry_ff_01: lat=%0d S=%h COUT=%b, want 5 00 1", lat, S, COUT);
        end
        tick();
        run_op(8'hFF, 8'hFF, 1'b1, lat);
        tests++;
        if (lat !== 5 || S !== 8'hFF || COUT !== 1'b1) begin
            fails++;
            $display("FAIL carry_ff_ff_1: lat=%0d S=%h COUT=%b, want 5 ff 1", lat, S, COUT);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        A = 8'h77; B = 8'h66; CIN = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        RST = 1'b1;
        tick(); tick();
        tests++;
        if (S !== 8'h00 || COUT !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: S=%h COUT=%b BUSY=%b DONE=%b, want 00 0 0 0",
                     S, COUT, BUSY, DONE);
        end
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_no_done cycle %0d: DONE=%b BUSY=%b, want 0 0",
                         i, DONE, BUSY);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3] = '{8'h01, 8'h80, 8'hAA};
        logic [7:0] vb [3] = '{8'h02, 8'h7F, 8'h55};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] es [3] = '{8'h03, 8'h00, 8'hFF};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        A = va[0]; B = vb[0]; CIN = vc[0]; START = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            lat = 1;
            while (!DONE && lat < 20) begin
                tick();
                lat++;
            end
            tests++;
            if (lat !== 5 || S !== es[k] || COUT !== ec[k]) begin
                fails++;
                $display("FAIL back_to_back op %0d: lat=%0d S=%h COUT=%b, want 5 %h %b",
                         k, lat, S, COUT, es[k], ec[k]);
            end
            // New operands during FIN; START is still high so they are taken now.
            if (k < 2) begin
                A = va[k+1]; B = vb[k+1]; CIN = vc[k+1];
            end else begin
                START = 1'b0;
            end
            tick();
        end
        tests++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back_idle: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        A = 8'h12; B = 8'h34; CIN = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        lat = 1;
        // S still holds 8'hFF from the previous operation while RUN proceeds.
        while (!DONE && lat < 20) begin
            A = 8'hFF; B = 8'hFF; CIN = 1'b1;
            START = (lat == 2);
            tests++;
            if (S !== 8'hFF) begin
                fails++;
                $display("FAIL ignore_hold cycle %0d: S=%h, want ff", lat, S);
            end
            tick();
            lat++;
        end
        START = 1'b0;
        tests++;
        if (lat !== 5 || S !== 8'h47 || COUT !== 1'b0) begin
            fails++;
            $display("FAIL ignore_result: lat=%0d S=%h COUT=%b, want 5 47 0", lat, S, COUT);
        end
        tick();
        tests++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_restart: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_full_chunk();
        A = 8'h80; B = 8'h80; CIN = 1'b0; START8 = 1'b1;
        tick();
        START8 = 1'b0;
        tests++;
        if (BUSY8 !== 1'b1 || DONE8 !== 1'b0) begin
            fails++;
            $display("FAIL full_chunk_busy: BUSY=%b DONE=%b, want 1 0", BUSY8, DONE8);
        end
        tick();
        tests++;
        if (DONE8 !== 1'b1 || BUSY8 !== 1'b0 || S8 !== 8'h00 || COUT8 !== 1'b1) begin
            fails++;
            $display("FAIL full_chunk_result: DONE=%b BUSY=%b S=%h COUT=%b, want 1 0 00 1",
                     DONE8, BUSY8, S8, COUT8);
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] a, b;
        logic       c, s;
        logic [8:0] exp;
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
`ifdef ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            SUB = s;
            exp = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
            run_op(a, b, c, lat);
            tests++;
            if (lat !== 5 || {COUT, S} !== exp) begin
                fails++;
                $display("FAIL random %0d (a=%h b=%h c=%b sub=%b): lat=%0d got %b_%h, want 5 %b_%h",
                         i, a, b, c, s, lat, COUT, S, exp[8], exp[7:0]);
            end
            tick();
        end
        SUB = 1'b0;
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        int lat;
        SUB = 1'b1;
        run_op(8'h05, 8'h07, 1'b0, lat);
        tests++;
        if (lat !== 5 || S !== 8'hFE || COUT !== 1'b0) begin
            fails++;
            $display("FAIL sub_5_7: lat=%0d S=%h COUT=%b, want 5 fe 0", lat, S, COUT);
        end
        tick();
        run_op(8'h07, 8'h05, 1'b0, lat);
        tests++;
        if (lat !== 5 || S !== 8'h02 || COUT !== 1'b1) begin
            fails++;
            $display("FAIL sub_7_5: lat=%0d S=%h COUT=%b, want 5 02 1", lat, S, COUT);
        end
        tick();
        SUB = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_reset_mid();
        test_back_to_back();
        test_ignore_start();
        test_full_chunk();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
